// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared ADC constants and the averager output-FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

  // Width of one aligned ADC code {MSBs, LSBs}
  localparam int ADC_CODE_W = 6;

  // Output register occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage : adc_pkg
`default_nettype wire

// File: rtl/code_averager.sv
`default_nettype none
// ============================================================================
// Module      : code_averager
// Description : Block averager for aligned ADC codes. Sums 2^OSR_LOG2 samples,
//               rounds (or truncates) and saturates the mean, and hands it to
//               a one-deep valid/ready output register with a sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module code_averager
  import adc_pkg::*;
#(
  parameter int OSR_LOG2 = 2,
  parameter int ROUND    = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADC_CODE_W-1:0] din_i,
  input  logic                  din_valid_i,
  input  logic                  clear_i,
  output logic [ADC_CODE_W-1:0] avg_o,
  output logic                  avg_valid_o,
  input  logic                  avg_ready_i,
  output logic                  overrun_o
);

  localparam int ACC_W = ADC_CODE_W + OSR_LOG2;
  // One spare bit so the rounding constant can never wrap the final sum
  localparam int SUM_W = ACC_W + 1;
  localparam logic [SUM_W-1:0] RND_ADD =
    (ROUND != 0) ? (SUM_W'(1) << (OSR_LOG2 - 1)) : '0;

  logic [ACC_W-1:0]      acc;
  logic [OSR_LOG2-1:0]   cnt;
  logic                  sample_take;
  logic                  block_done;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      shifted;
  logic [ADC_CODE_W-1:0] avg_next;
  out_state_t            state;
  out_state_t            state_n;
  logic                  load_avg;
  logic                  set_ovr;

  // Clear wins over a sample arriving in the same cycle
  assign sample_take = din_valid_i & ~clear_i;
  assign block_done  = sample_take & (&cnt);

  // Final sum includes the Nth sample being taken on this edge
  assign sum      = {1'b0, acc} + SUM_W'(din_i) + RND_ADD;
  assign shifted  = sum >> OSR_LOG2;
  assign avg_next = (|shifted[SUM_W-1:ADC_CODE_W]) ? '1 : shifted[ADC_CODE_W-1:0];

  // Accumulator and sample counter; restart immediately after each block
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear_i || block_done) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_take) begin
      acc <= acc + ACC_W'(din_i);
      cnt <= cnt + OSR_LOG2'(1);
    end
  end

  // Output FSM state register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Output FSM next state: load, drain or drop-with-overrun decisions
  always_comb begin
    state_n  = state;
    load_avg = 1'b0;
    set_ovr  = 1'b0;
    if (clear_i) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (block_done) begin
            load_avg = 1'b1;
            state_n  = FULL;
          end
        end
        FULL: begin
          if (block_done) begin
            // Slot frees on this edge only if downstream takes the old result
            if (avg_ready_i) begin
              load_avg = 1'b1;
            end else begin
              set_ovr = 1'b1;
            end
          end else if (avg_ready_i) begin
            state_n = EMPTY;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // Output data register and sticky overrun flag
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      avg_o     <= '0;
      overrun_o <= 1'b0;
    end else if (clear_i) begin
      avg_o     <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (load_avg) begin
        avg_o <= avg_next;
      end
      if (set_ovr) begin
        overrun_o <= 1'b1;
      end
    end
  end

  assign avg_valid_o = (state == FULL);

endmodule : code_averager
`default_nettype wire

// File: tb/tb_code_averager.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_averager
// Description : Directed self-checking bench for code_averager (OSR_LOG2=2),
//               with a truncating instance alongside the rounding one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_averager;

  logic       clk;
  logic       reset_i;
  logic [5:0] din;
  logic       din_valid;
  logic       clear;
  logic       avg_ready;
  logic [5:0] avg_r;
  logic       avg_valid_r;
  logic       overrun_r;
  logic [5:0] avg_t;
  logic       avg_valid_t;
  logic       overrun_t;

  int checks = 0;
  int errors = 0;

  code_averager #(.OSR_LOG2(2), .ROUND(1)) dut (
    .clk_i(clk), .reset_i(reset_i), .din_i(din), .din_valid_i(din_valid),
    .clear_i(clear), .avg_o(avg_r), .avg_valid_o(avg_valid_r),
    .avg_ready_i(avg_ready), .overrun_o(overrun_r)
  );

  code_averager #(.OSR_LOG2(2), .ROUND(0)) dut_trunc (
    .clk_i(clk), .reset_i(reset_i), .din_i(din), .din_valid_i(din_valid),
    .clear_i(clear), .avg_o(avg_t), .avg_valid_o(avg_valid_t),
    .avg_ready_i(avg_ready), .overrun_o(overrun_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one sample; it is taken on the next rising edge
  task automatic push(input logic [5:0] v);
    @(negedge clk);
    din       = v;
    din_valid = 1'b1;
  endtask

  // Stop presenting samples; the previous one has been taken by now
  task automatic idle();
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    din_valid = 1'b0;
    clear     = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
  endtask

  initial begin
    reset_i   = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    clear     = 1'b0;
    avg_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_avg", {2'b0, avg_r}, 8'd0);
    check("rst_valid", {7'b0, avg_valid_r}, 8'd0);
    check("rst_ovr", {7'b0, overrun_r}, 8'd0);
    reset_i = 1'b1;

    // Basic average with one-cycle latency
    push(6'd10); push(6'd11); push(6'd12); push(6'd13);
    check("lat_before", {7'b0, avg_valid_r}, 8'd0);
    idle();
    check("basic_valid", {7'b0, avg_valid_r}, 8'd1);
    check("basic_avg", {2'b0, avg_r}, 8'd12);
    @(negedge clk);
    check("basic_drain", {7'b0, avg_valid_r}, 8'd0);

    // Rounding versus truncation
    push(6'd1); push(6'd1); push(6'd1); push(6'd2);
    idle();
    check("rnd_1112", {2'b0, avg_r}, 8'd1);
    push(6'd1); push(6'd1); push(6'd2); push(6'd2);
    idle();
    check("rnd_1122", {2'b0, avg_r}, 8'd2);
    check("trunc_1122", {2'b0, avg_t}, 8'd1);
    check("trunc_valid", {7'b0, avg_valid_t}, 8'd1);

    // Saturation at full scale
    push(6'd63); push(6'd63); push(6'd63); push(6'd63);
    idle();
    check("sat_avg", {2'b0, avg_r}, 8'd63);
    @(negedge clk);

    // Overrun: first result held, later ones dropped
    avg_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(6'd20);
    for (int i = 0; i < 8; i++) push(6'd40);
    idle();
    check("ovr_avg", {2'b0, avg_r}, 8'd20);
    check("ovr_valid", {7'b0, avg_valid_r}, 8'd1);
    check("ovr_flag", {7'b0, overrun_r}, 8'd1);
    @(negedge clk);
    check("ovr_stable", {2'b0, avg_r}, 8'd20);
    avg_ready = 1'b1;
    @(negedge clk);
    check("ovr_drain", {7'b0, avg_valid_r}, 8'd0);
    check("ovr_sticky", {7'b0, overrun_r}, 8'd1);

    // Clear with a coincident sample discards it and restarts the block
    push(6'd7); push(6'd7); push(6'd7);
    @(negedge clk);
    din       = 6'd60;
    din_valid = 1'b1;
    clear     = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
    din_valid = 1'b0;
    check("clr_valid", {7'b0, avg_valid_r}, 8'd0);
    check("clr_ovr", {7'b0, overrun_r}, 8'd0);
    push(6'd5); push(6'd5); push(6'd5);
    idle();
    check("clr_partial", {7'b0, avg_valid_r}, 8'd0);
    push(6'd5);
    idle();
    check("clr_valid2", {7'b0, avg_valid_r}, 8'd1);
    check("clr_avg", {2'b0, avg_r}, 8'd5);
    @(negedge clk);

    // Asynchronous reset in mid-block, with a held result present
    avg_ready = 1'b0;
    push(6'd8); push(6'd8); push(6'd8); push(6'd8);
    push(6'd50); push(6'd50);
    idle();
    check("pre_rst_avg", {2'b0, avg_r}, 8'd8);
    #2;
    reset_i = 1'b0;
    #1;
    check("arst_avg", {2'b0, avg_r}, 8'd0);
    check("arst_valid", {7'b0, avg_valid_r}, 8'd0);
    @(negedge clk);
    reset_i   = 1'b1;
    avg_ready = 1'b1;
    push(6'd4); push(6'd4); push(6'd4); push(6'd4);
    idle();
    check("rst_blk_valid", {7'b0, avg_valid_r}, 8'd1);
    check("rst_blk_avg", {2'b0, avg_r}, 8'd4);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_code_averager
`default_nettype wire

// File: doc/code_averager.md
CODE_AVERAGER -- requirements
Module: code_averager

Interface
REQ-001 The block SHALL have parameter OSR_LOG2, default 2, meaning log2 of samples per average block (legal 1..4; N = 2^OSR_LOG2).
REQ-002 The block SHALL have parameter ROUND, default 1, meaning 1 = round-half-up and 0 = truncate.
REQ-003 The block SHALL have port clk_i, input, 1 bit: system clock, all logic on rising edge.
REQ-004 The block SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port din_i, input, 6 bits: aligned code {MSBs, LSBs} from the time-alignment stage.
REQ-006 The block SHALL have port din_valid_i, input, 1 bit: din_i holds a new sample this cycle.
REQ-007 The block SHALL have port clear_i, input, 1 bit: synchronous flush of the partial block, output register and overrun flag.
REQ-008 The block SHALL have port avg_o, output, 6 bits: averaged code.
REQ-009 The block SHALL have port avg_valid_o, output, 1 bit: avg_o holds an unconsumed result.
REQ-010 The block SHALL have port avg_ready_i, input, 1 bit: downstream accepts avg_o when high together with avg_valid_o.
REQ-011 The block SHALL have port overrun_o, output, 1 bit: sticky flag, a completed result was dropped.

Function
REQ-012 The accumulator SHALL be 6+OSR_LOG2 bits wide, with a sample counter of OSR_LOG2 bits; no accumulator overflow is possible.
REQ-013 Each cycle with din_valid_i=1 and clear_i=0 SHALL add din_i to the accumulator and increment the counter.
REQ-014 On the edge accepting the Nth sample, the block SHALL compute (acc + din_i + (ROUND ? 2^(OSR_LOG2-1) : 0)) >> OSR_LOG2, saturate it to 63, and zero the accumulator and counter on that same edge.
REQ-015 Accumulation SHALL continue without gaps while a result is pending; the next block starts on the following sample.
REQ-016 The output register SHALL be a two-state FSM: EMPTY (avg_valid_o=0) and FULL (avg_valid_o=1).
REQ-017 In EMPTY, a block completion SHALL load avg_o and move to FULL; avg_valid_o is high in the cycle after the completing edge (latency 1 cycle from the Nth sample).
REQ-018 In FULL with avg_ready_i=1 and no completion, the FSM SHALL move to EMPTY.
REQ-019 In FULL with avg_ready_i=1 and a completion on the same edge, the block SHALL load the new result and stay in FULL.
REQ-020 In FULL with avg_ready_i=0 and a completion, the block SHALL drop the new result, keep the old avg_o, and set overrun_o.
REQ-021 avg_o SHALL remain stable while avg_valid_o=1 and avg_ready_i=0.
REQ-022 overrun_o SHALL stay set until clear_i or reset.
REQ-023 clear_i=1 SHALL zero the accumulator and counter, force EMPTY and clear overrun_o; a din_valid_i sample in the same cycle is discarded, because clear has priority.
REQ-024 avg_ready_i while in EMPTY SHALL have no effect.

Reset
REQ-025 While reset_i=0, the block SHALL hold avg_o=0, avg_valid_o=0, overrun_o=0, accumulator=0, counter=0 and FSM=EMPTY, asynchronously.
REQ-026 Reset asserted mid-block SHALL discard the partial sum; after release, counting SHALL restart at sample 1.

Structure
REQ-027 A shared package adc_pkg SHALL hold the ADC_CODE_W=6 constant and the output-FSM state enum (EMPTY, FULL).
REQ-028 The block SHALL be a single module with no sub-module; accumulator, rounding/saturation and output FSM are all inline.

Verification (OSR_LOG2=2, ROUND=1 unless stated)
REQ-029 Samples 10,11,12,13 on consecutive cycles with ready=1 -> avg_o=12 with avg_valid_o high one cycle after the 13 is taken.
REQ-030 Rounding: 1,1,1,2 -> 1 and 1,1,2,2 -> 2; with ROUND=0, 1,1,2,2 -> 1.
REQ-031 Saturation: 63,63,63,63 -> avg_o=63, no wrap.
REQ-032 Overrun: ready=0 for eight samples of 20 then eight of 40 -> avg_o=20 held, overrun_o=1; ready=1 then -> one handshake, then EMPTY.
REQ-033 Reset asserted after two samples of 50, released, then 4,4,4,4 -> avg_o=4.
REQ-034 clear_i with din_valid_i=1 after three samples -> that sample is discarded, avg_valid_o=0, overrun_o=0, and the next four samples form a fresh block.
